// File: rtl/burst_serial_peer_if.sv
// User-side bundle of burst_serial_peer: transmit enqueue handshake, receive
// byte with ack/overrun, and mode/status lines.
interface burst_serial_peer_if;
  logic       tx_mode;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_overrun;

  modport master (
    output tx_mode, tx_data, tx_valid, rx_ack,
    input  tx_ready, tx_done, busy, rx_data, rx_valid, rx_overrun
  );

  modport slave (
    input  tx_mode, tx_data, tx_valid, rx_ack,
    output tx_ready, tx_done, busy, rx_data, rx_valid, rx_overrun
  );
endinterface

// File: rtl/burst_serial_peer.sv
// Drive-side peer of the fast-serial CNT/SP open-drain pair: MSB-first byte RX
// from host clocking, and MSB-first TX from a small FIFO with self-generated CNT.
module burst_serial_peer #(
  parameter int HALF_PERIOD = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               E_CLK,
  input  logic               RESET_n,
  burst_serial_peer_if.slave bus,
  inout  wire                CNT,
  inout  wire                SP
);
  localparam int TW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] T_LAST = TW'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, SETUP, LOW} state_t;

  // Synchronisers reset to 1 so a pulled-up idle line never looks like a rise.
  logic [SYNC_STAGES-1:0] cnt_sync_q, sp_sync_q;
  logic                   cnt_prev_q, sp_prev_q;

  always_ff @(posedge E_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      cnt_sync_q <= '1;
      sp_sync_q  <= '1;
      cnt_prev_q <= 1'b1;
      sp_prev_q  <= 1'b1;
    end else begin
      cnt_sync_q <= {cnt_sync_q[SYNC_STAGES-2:0], CNT};
      sp_sync_q  <= {sp_sync_q[SYNC_STAGES-2:0], SP};
      cnt_prev_q <= cnt_sync_q[SYNC_STAGES-1];
      sp_prev_q  <= sp_sync_q[SYNC_STAGES-1];
    end
  end

  logic cnt_rise;
  assign cnt_rise = cnt_sync_q[SYNC_STAGES-1] & ~cnt_prev_q;

  // Data is taken alongside the last low CNT sample: a transmitter may move SP
  // on the same edge that releases CNT.
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [2:0] rx_cnt_q, rx_cnt_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d, rx_overrun_q, rx_overrun_d;
  logic       rx_done;

  always_comb begin
    rx_shift_d   = rx_shift_q;
    rx_cnt_d     = rx_cnt_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = rx_overrun_q;
    rx_done      = 1'b0;
    if (bus.tx_mode) begin
      rx_shift_d = '0;
      rx_cnt_d   = '0;
    end else if (cnt_rise) begin
      rx_shift_d = {rx_shift_q[5:0], sp_prev_q};
      rx_cnt_d   = rx_cnt_q + 3'd1;
      rx_done    = (rx_cnt_q == 3'd7);
    end
    if (rx_done) begin
      rx_data_d  = {rx_shift_q, sp_prev_q};
      rx_valid_d = 1'b1;
      if (rx_valid_q && !bus.rx_ack) rx_overrun_d = 1'b1;
    end else if (bus.rx_ack) begin
      rx_valid_d   = 1'b0;
      rx_overrun_d = 1'b0;
    end
  end

  always_ff @(posedge E_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      rx_shift_q   <= '0;
      rx_cnt_q     <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_shift_q   <= rx_shift_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  // TX FIFO; held flushed whenever the port is in receive mode.
  logic [7:0]  fifo_mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        fifo_empty, fifo_full, push, pop;

  assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
  assign fifo_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign bus.tx_ready = bus.tx_mode && !fifo_full;
  assign push         = bus.tx_valid && bus.tx_ready;

  always_ff @(posedge E_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (!bus.tx_mode) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge E_CLK) begin
    if (push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= bus.tx_data;
  end

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_done_c;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_d      = bit_q;
    tx_shift_d = tx_shift_q;
    pop        = 1'b0;
    tx_done_c  = 1'b0;
    if (!bus.tx_mode) begin
      state_d    = IDLE;
      timer_d    = '0;
      bit_d      = '0;
      tx_shift_d = '0;
    end else begin
      case (state_q)
        IDLE: if (!fifo_empty) begin
          pop        = 1'b1;
          tx_shift_d = fifo_mem_q[rd_ptr_q[AW-1:0]];
          bit_d      = '0;
          timer_d    = '0;
          state_d    = SETUP;
        end
        SETUP: if (timer_q == T_LAST) begin
          timer_d = '0;
          state_d = LOW;
        end else begin
          timer_d = timer_q + 1'b1;
        end
        LOW: if (timer_q == T_LAST) begin
          timer_d = '0;
          if (bit_q != 3'd7) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
            bit_d      = bit_q + 3'd1;
            state_d    = SETUP;
          end else begin
            // Next byte follows straight on so back-to-back bytes have no idle gap.
            tx_done_c = 1'b1;
            if (!fifo_empty) begin
              pop        = 1'b1;
              tx_shift_d = fifo_mem_q[rd_ptr_q[AW-1:0]];
              bit_d      = '0;
              state_d    = SETUP;
            end else begin
              state_d = IDLE;
            end
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge E_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_q      <= '0;
      tx_shift_q <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_q      <= bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  // Line drivers are gated by tx_mode directly so a mode drop releases them at once.
  assign CNT = (bus.tx_mode && state_q == LOW) ? 1'b0 : 1'bz;
  assign SP  = (bus.tx_mode && state_q != IDLE && !tx_shift_q[7]) ? 1'b0 : 1'bz;

  assign bus.tx_done    = tx_done_c;
  assign bus.busy       = (state_q != IDLE) || !fifo_empty;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.rx_overrun = rx_overrun_q;
endmodule

// File: tb/tb_burst_serial_peer.sv
// Bench for burst_serial_peer: host-driven RX, TX waveform capture, and a
// loopback against a second, slower-clocked instance on the shared lines.
module tb_burst_serial_peer;
  logic E_CLK   = 1'b0;
  logic RESET_n = 1'b0;
  logic host_cnt_low = 1'b0;
  logic host_sp_low  = 1'b0;
  wire  cnt_line, sp_line;

  int errors = 0;
  int checks = 0;
  logic [7:0] rx_exp_q[$];
  logic [7:0] tx_exp_q[$];

  logic       mon_en  = 1'b0;
  logic       mon_clr = 1'b0;
  int         mon_bits = 0;
  logic [7:0] mon_acc = 8'h00;
  logic       mon_sp_last  = 1'b1;
  logic       mon_cnt_prev = 1'b1;
  logic [7:0] got_mem [16];
  int         got_wr = 0;
  int         got_rd = 0;

  always #5 E_CLK = ~E_CLK;

  pullup (cnt_line);
  pullup (sp_line);
  assign cnt_line = host_cnt_low ? 1'b0 : 1'bz;
  assign sp_line  = host_sp_low  ? 1'b0 : 1'bz;

  burst_serial_peer_if bus_d ();
  burst_serial_peer_if bus_p ();

  burst_serial_peer #(.HALF_PERIOD(2), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .E_CLK(E_CLK), .RESET_n(RESET_n), .bus(bus_d), .CNT(cnt_line), .SP(sp_line)
  );

  // Slower peer: its 4-cycle CNT phases respect the receive rate limit.
  burst_serial_peer #(.HALF_PERIOD(4), .FIFO_DEPTH(4), .SYNC_STAGES(2)) peer (
    .E_CLK(E_CLK), .RESET_n(RESET_n), .bus(bus_p), .CNT(cnt_line), .SP(sp_line)
  );

  // Line monitor: SP is held while CNT is low, and the byte is built on CNT rises.
  always @(negedge E_CLK) begin
    mon_cnt_prev <= cnt_line;
    if (mon_clr) begin
      mon_bits <= 0;
    end else if (mon_en) begin
      if (cnt_line === 1'b0) begin
        mon_sp_last <= sp_line;
      end else if (mon_cnt_prev === 1'b0) begin
        mon_acc <= {mon_acc[6:0], mon_sp_last};
        if (mon_bits == 7) begin
          got_mem[got_wr[3:0]] <= {mon_acc[6:0], mon_sp_last};
          got_wr   <= got_wr + 1;
          mon_bits <= 0;
        end else begin
          mon_bits <= mon_bits + 1;
        end
      end
    end
  end

  task automatic tick;
    @(posedge E_CLK);
    #1;
  endtask

  task automatic mon_restart;
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
    got_rd  = got_wr;
  endtask

  // Host clocks one byte MSB first with 4-cycle phases; returns 3 cycles after
  // the 8th rise, optionally with rx_ack held across the completion cycle.
  task automatic host_send(input logic [7:0] b, input bit ack_last);
    rx_exp_q.push_back(b);
    for (int i = 7; i >= 0; i--) begin
      host_sp_low  = ~b[i];
      host_cnt_low = 1'b1;
      repeat (4) tick();
      host_cnt_low = 1'b0;
      if (i != 0) begin
        repeat (4) tick();
      end else begin
        repeat (2) tick();
        bus_d.rx_ack = ack_last;
        tick();
        bus_d.rx_ack = 1'b0;
      end
    end
    host_sp_low = 1'b0;
  endtask

  task automatic wait_tx_done(output int n);
    n = 1;
    tick();
    while (bus_d.tx_done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    repeat (2) tick();
    checks++; if (bus_d.tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready: got %b expected 0", bus_d.tx_ready); end
    checks++; if (bus_d.tx_done !== 1'b0 || bus_d.busy !== 1'b0) begin errors++; $display("FAIL reset_done_busy: got %b%b expected 00", bus_d.tx_done, bus_d.busy); end
    checks++; if (bus_d.rx_data !== 8'h00 || bus_d.rx_valid !== 1'b0 || bus_d.rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_rx: got data=%h v=%b ovr=%b expected 00/0/0", bus_d.rx_data, bus_d.rx_valid, bus_d.rx_overrun); end
    checks++; if (cnt_line !== 1'b1 || sp_line !== 1'b1) begin errors++; $display("FAIL reset_lines: got cnt=%b sp=%b expected released (1/1)", cnt_line, sp_line); end
    RESET_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_rx_byte;
    logic [7:0] exp;
    host_send(8'hA5, 1'b0);
    exp = rx_exp_q.pop_front();
    checks++; if (bus_d.rx_valid !== 1'b1 || bus_d.rx_data !== exp) begin errors++; $display("FAIL rx_byte: got v=%b data=%h expected 1/%h", bus_d.rx_valid, bus_d.rx_data, exp); end
    checks++; if (bus_d.rx_overrun !== 1'b0) begin errors++; $display("FAIL rx_byte_overrun: got %b expected 0", bus_d.rx_overrun); end
    repeat (4) tick();
  endtask

  task automatic test_rx_overrun;
    logic [7:0] exp;
    host_send(8'h3C, 1'b0);
    exp = rx_exp_q.pop_front();
    checks++; if (bus_d.rx_data !== exp || bus_d.rx_overrun !== 1'b1) begin errors++; $display("FAIL rx_overrun_set: got data=%h ovr=%b expected %h/1", bus_d.rx_data, bus_d.rx_overrun, exp); end
    bus_d.rx_ack = 1'b1;
    tick();
    bus_d.rx_ack = 1'b0;
    checks++; if (bus_d.rx_valid !== 1'b0 || bus_d.rx_overrun !== 1'b0) begin errors++; $display("FAIL rx_ack_clear: got v=%b ovr=%b expected 0/0", bus_d.rx_valid, bus_d.rx_overrun); end
    repeat (4) tick();
  endtask

  task automatic test_rx_ack_coincident;
    logic [7:0] exp;
    host_send(8'h5A, 1'b0);
    exp = rx_exp_q.pop_front();
    checks++; if (bus_d.rx_data !== exp || bus_d.rx_valid !== 1'b1) begin errors++; $display("FAIL rx_first: got data=%h v=%b expected %h/1", bus_d.rx_data, bus_d.rx_valid, exp); end
    repeat (4) tick();
    host_send(8'hC6, 1'b1);
    exp = rx_exp_q.pop_front();
    checks++; if (bus_d.rx_data !== exp || bus_d.rx_valid !== 1'b1 || bus_d.rx_overrun !== 1'b0) begin errors++; $display("FAIL rx_ack_coincident: got data=%h v=%b ovr=%b expected %h/1/0", bus_d.rx_data, bus_d.rx_valid, bus_d.rx_overrun, exp); end
    bus_d.rx_ack = 1'b1;
    tick();
    bus_d.rx_ack = 1'b0;
    checks++; if (bus_d.rx_valid !== 1'b0) begin errors++; $display("FAIL rx_ack_after: got v=%b expected 0", bus_d.rx_valid); end
    repeat (4) tick();
  endtask

  task automatic test_tx_byte;
    int n;
    bus_d.tx_mode = 1'b1;
    mon_en = 1'b1;
    mon_restart();
    tick();
    checks++; if (bus_d.tx_ready !== 1'b1) begin errors++; $display("FAIL tx_ready_mode: got %b expected 1", bus_d.tx_ready); end
    bus_d.tx_data  = 8'h96;
    bus_d.tx_valid = 1'b1;
    tx_exp_q.push_back(8'h96);
    @(posedge E_CLK);
    #1 bus_d.tx_valid = 1'b0;
    n = 1;
    while (bus_d.tx_done !== 1'b1 && n < 100) begin tick(); n++; end
    checks++; if (n != 33) begin errors++; $display("FAIL tx_latency: got %0d cycles expected 33", n); end
    tick();
    checks++; if (bus_d.tx_done !== 1'b0 || bus_d.busy !== 1'b0) begin errors++; $display("FAIL tx_after_done: got done=%b busy=%b expected 0/0", bus_d.tx_done, bus_d.busy); end
    checks++; if (cnt_line !== 1'b1 || sp_line !== 1'b1) begin errors++; $display("FAIL tx_lines_idle: got cnt=%b sp=%b expected 1/1", cnt_line, sp_line); end
    tick();
    checks++; if (got_wr == got_rd || got_mem[got_rd[3:0]] !== tx_exp_q[0]) begin errors++; $display("FAIL tx_waveform: got %0d bytes, last %h expected %h", got_wr - got_rd, got_mem[got_rd[3:0]], tx_exp_q[0]); end
    void'(tx_exp_q.pop_front());
    got_rd = got_wr;
  endtask

  task automatic test_back_to_back;
    int t, ndone, gaps, extra;
    int done_t[5];
    for (int i = 0; i < 5; i++) begin
      bus_d.tx_data  = 8'(i + 1);
      bus_d.tx_valid = 1'b1;
      tx_exp_q.push_back(8'(i + 1));
      tick();
    end
    checks++; if (bus_d.tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got tx_ready=%b expected 0", bus_d.tx_ready); end
    bus_d.tx_data = 8'hEE;
    tick();
    bus_d.tx_valid = 1'b0;
    t = 0; ndone = 0; gaps = 0;
    while (ndone < 5 && t < 400) begin
      if (bus_d.tx_done === 1'b1) begin done_t[ndone] = t; ndone++; end
      else if (ndone > 0 && bus_d.busy !== 1'b1) gaps++;
      tick();
      t++;
    end
    checks++; if (ndone != 5 || gaps != 0) begin errors++; $display("FAIL b2b_pulses: got %0d pulses, %0d idle cycles expected 5 and 0", ndone, gaps); end
    for (int i = 1; i < ndone; i++) begin
      checks++; if (done_t[i] - done_t[i-1] != 32) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d expected 32", i, done_t[i] - done_t[i-1]); end
    end
    tick();
    while (tx_exp_q.size() > 0) begin
      checks++; if (got_wr == got_rd || got_mem[got_rd[3:0]] !== tx_exp_q[0]) begin errors++; $display("FAIL b2b_byte: got %h expected %h", got_mem[got_rd[3:0]], tx_exp_q[0]); end
      void'(tx_exp_q.pop_front());
      if (got_rd < got_wr) got_rd++;
    end
    extra = 0;
    repeat (40) begin tick(); if (bus_d.tx_done === 1'b1) extra++; end
    checks++; if (extra != 0 || got_wr != got_rd) begin errors++; $display("FAIL b2b_dropped_push: got %0d extra pulses, %0d extra bytes expected 0/0", extra, got_wr - got_rd); end
  endtask

  task automatic test_loopback;
    int n;
    logic [7:0] exp;
    mon_en = 1'b0;
    bus_d.tx_mode = 1'b0;
    bus_p.tx_mode = 1'b1;
    repeat (4) tick();
    bus_p.tx_data = 8'hFF; bus_p.tx_valid = 1'b1; rx_exp_q.push_back(8'hFF); tick();
    bus_p.tx_data = 8'h00; rx_exp_q.push_back(8'h00); tick();
    bus_p.tx_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (bus_d.rx_valid !== 1'b1 && n < 300) begin tick(); n++; end
      exp = rx_exp_q.pop_front();
      checks++; if (bus_d.rx_valid !== 1'b1 || bus_d.rx_data !== exp || bus_d.rx_overrun !== 1'b0) begin errors++; $display("FAIL loopback[%0d]: got v=%b data=%h ovr=%b expected 1/%h/0", k, bus_d.rx_valid, bus_d.rx_data, bus_d.rx_overrun, exp); end
      bus_d.rx_ack = 1'b1;
      tick();
      bus_d.rx_ack = 1'b0;
    end
    repeat (40) tick();
    checks++; if (bus_d.rx_valid !== 1'b0 || bus_p.busy !== 1'b0) begin errors++; $display("FAIL loopback_end: got rx_valid=%b peer_busy=%b expected 0/0", bus_d.rx_valid, bus_p.busy); end
    bus_p.tx_mode = 1'b0;
  endtask

  task automatic test_mode_drop;
    int n, extra;
    bus_d.tx_mode = 1'b1;
    mon_en = 1'b1;
    mon_restart();
    bus_d.tx_data = 8'hC3; bus_d.tx_valid = 1'b1; tick(); bus_d.tx_valid = 1'b0;
    n = 0;
    while (mon_bits != 3 && n < 100) begin tick(); n++; end
    checks++; if (mon_bits != 3) begin errors++; $display("FAIL drop_wait: got %0d bits expected 3", mon_bits); end
    bus_d.tx_mode = 1'b0;
    #1;
    checks++; if (cnt_line !== 1'b1 || sp_line !== 1'b1) begin errors++; $display("FAIL drop_lines: got cnt=%b sp=%b expected 1/1", cnt_line, sp_line); end
    extra = 0;
    repeat (40) begin tick(); if (bus_d.tx_done === 1'b1) extra++; end
    checks++; if (extra != 0 || bus_d.busy !== 1'b0 || got_wr != got_rd) begin errors++; $display("FAIL drop_quiet: got pulses=%0d busy=%b bytes=%0d expected 0/0/0", extra, bus_d.busy, got_wr - got_rd); end
  endtask

  task automatic test_reset_mid_byte;
    int n, extra;
    bus_d.tx_mode = 1'b1;
    mon_restart();
    tick();
    bus_d.tx_data = 8'h00; bus_d.tx_valid = 1'b1; tick(); bus_d.tx_valid = 1'b0;
    n = 0;
    while (!(mon_bits == 2 && cnt_line === 1'b0) && n < 100) begin tick(); n++; end
    checks++; if (cnt_line !== 1'b0 || sp_line !== 1'b0) begin errors++; $display("FAIL rst_pre: got cnt=%b sp=%b expected 0/0", cnt_line, sp_line); end
    RESET_n = 1'b0;
    #1;
    checks++; if (cnt_line !== 1'b1 || sp_line !== 1'b1 || bus_d.busy !== 1'b0) begin errors++; $display("FAIL rst_mid: got cnt=%b sp=%b busy=%b expected 1/1/0", cnt_line, sp_line, bus_d.busy); end
    repeat (2) tick();
    RESET_n = 1'b1;
    mon_restart();
    extra = 0;
    repeat (40) begin tick(); if (bus_d.tx_done === 1'b1) extra++; end
    checks++; if (extra != 0 || got_wr != got_rd || bus_d.rx_valid !== 1'b0) begin errors++; $display("FAIL rst_quiet: got pulses=%0d bytes=%0d rx_valid=%b expected 0/0/0", extra, got_wr - got_rd, bus_d.rx_valid); end
    bus_d.tx_data = 8'h81; bus_d.tx_valid = 1'b1; tx_exp_q.push_back(8'h81);
    wait_tx_done(n);
    bus_d.tx_valid = 1'b0;
    checks++; if (n != 33) begin errors++; $display("FAIL rst_next_latency: got %0d expected 33", n); end
    repeat (2) tick();
    checks++; if (got_wr == got_rd || got_mem[got_rd[3:0]] !== tx_exp_q[0]) begin errors++; $display("FAIL rst_next_byte: got %h expected %h", got_mem[got_rd[3:0]], tx_exp_q[0]); end
    void'(tx_exp_q.pop_front());
    got_rd = got_wr;
  endtask

  initial begin
    bus_d.tx_mode = 1'b0; bus_d.tx_data = 8'h00; bus_d.tx_valid = 1'b0; bus_d.rx_ack = 1'b0;
    bus_p.tx_mode = 1'b0; bus_p.tx_data = 8'h00; bus_p.tx_valid = 1'b0; bus_p.rx_ack = 1'b0;
    test_reset();
    test_rx_byte();
    test_rx_overrun();
    test_rx_ack_coincident();
    test_tx_byte();
    test_back_to_back();
    test_loopback();
    test_mode_drop();
    test_reset_mid_byte();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
